// File: rtl/debounce_counter_array.sv
// N_CH independent button channels: two-flop synchroniser, debounce FSM, edge detect
// with optional hold-to-repeat, and a per-channel wrap/saturate event counter.
module debounce_counter_array #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 4,
    parameter int DB_CYCLES     = 2_000_000,
    parameter int EDGE_MODE     = 0,
    parameter int WRAP          = 1,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       btn,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       db,
    output logic [N_CH-1:0]       event_tick,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       sat
);

    localparam int TMR_W = $clog2(DB_CYCLES + 1);
    localparam int RPT_W = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        db_state_e        state;
        logic [TMR_W-1:0] timer;
        logic             db_q;
        logic             db_d;
        logic             rise;
        logic             fall;
        logic             edge_evt;
        logic             rpt_hit;
        logic             evt;
        logic             tick_q;
        logic [CNT_W-1:0] cnt;
        logic             sat_q;

        // NOTE: non-blocking assignment makes the two stages shift one per clock
        // instead of collapsing into a single flop.
        always_ff @(posedge clk) begin
            if (reset) sync <= '0;
            else       sync <= {sync[0], btn[i]};
        end
        assign s = sync[1];

        // timer holds the number of consecutive new-level samples seen so far;
        // the DB_CYCLES-th one commits the level.
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= LOW;
                timer <= '0;
                db_q  <= 1'b0;
            end else begin
                case (state)
                    LOW: if (s) begin
                        if (DB_CYCLES == 1) begin
                            state <= HIGH;
                            db_q  <= 1'b1;
                        end else begin
                            state <= WAIT_HI;
                            timer <= TMR_W'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state <= LOW;
                        end else if (timer == TMR_LAST) begin
                            state <= HIGH;
                            db_q  <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    HIGH: if (!s) begin
                        if (DB_CYCLES == 1) begin
                            state <= LOW;
                            db_q  <= 1'b0;
                        end else begin
                            state <= WAIT_LO;
                            timer <= TMR_W'(1);
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state <= HIGH;
                        end else if (timer == TMR_LAST) begin
                            state <= LOW;
                            db_q  <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= LOW;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) db_d <= 1'b0;
            else       db_d <= db_q;
        end

        assign rise = db_q & ~db_d;
        assign fall = ~db_q & db_d;

        // NOTE: assigning a default first keeps this block purely combinational
        // (no latch) whatever EDGE_MODE selects.
        always_comb begin
            edge_evt = 1'b0;
            if (EDGE_MODE == 0)      edge_evt = rise;
            else if (EDGE_MODE == 1) edge_evt = fall;
            else                     edge_evt = rise | fall;
        end

        if (REPEAT_CYCLES > 0 && EDGE_MODE != 1) begin : g_rpt
            logic [RPT_W-1:0] rpt;
            logic [RPT_W-1:0] rpt_next;

            assign rpt_next = rpt + 1'b1;
            // Repeats fire every REPEAT_CYCLES cycles after the press edge.
            assign rpt_hit  = db_q & ~rise & (rpt_next == RPT_W'(REPEAT_CYCLES));

            always_ff @(posedge clk) begin
                if (reset || !db_q || rise || rpt_hit) rpt <= '0;
                else                                   rpt <= rpt_next;
            end
        end else begin : g_no_rpt
            assign rpt_hit = 1'b0;
        end

        assign evt = edge_evt | rpt_hit;

        always_ff @(posedge clk) begin
            if (reset) begin
                tick_q <= 1'b0;
                cnt    <= '0;
                sat_q  <= 1'b0;
            end else begin
                tick_q <= evt;
                if (clr[i]) begin
                    cnt   <= '0;
                    sat_q <= 1'b0;
                end else if (tick_q) begin
                    if (WRAP != 0)            cnt   <= cnt + 1'b1;
                    else if (cnt == CNT_MAX)  sat_q <= 1'b1;
                    else                      cnt   <= cnt + 1'b1;
                end
            end
        end

        assign db[i]                     = db_q;
        assign event_tick[i]             = tick_q;
        assign count[i*CNT_W +: CNT_W]   = cnt;
        assign sat[i]                    = (WRAP != 0) ? 1'b0 : sat_q;
    end

endmodule

// File: tb/tb_debounce_counter_array.sv
// Bench for debounce_counter_array: five configurations driven side by side, a
// per-cycle behavioural scoreboard, directed corner sequences and random stimulus.
module tb_debounce_counter_array;

    localparam int N_DUT = 5;
    localparam int N_CH  = 2;
    localparam int CNT_W = 3;
    localparam int DB    = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    // 0: press/wrap  1: press/saturate  2: both edges  3: press+repeat 8  4: release+repeat 8
    function automatic int cfg_mode(input int g);
        case (g)
            2:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_wrap(input int g);
        return (g == 1) ? 0 : 1;
    endfunction
    function automatic int cfg_rpt(input int g);
        return (g >= 3) ? 8 : 0;
    endfunction

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       btn  [N_DUT];
    logic [N_CH-1:0]       clr  [N_DUT];
    logic [N_CH-1:0]       db   [N_DUT];
    logic [N_CH-1:0]       tick [N_DUT];
    logic [N_CH-1:0]       sat  [N_DUT];
    logic [N_CH*CNT_W-1:0] cnt  [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        debounce_counter_array #(
            .N_CH(N_CH), .CNT_W(CNT_W), .DB_CYCLES(DB),
            .EDGE_MODE(cfg_mode(g)), .WRAP(cfg_wrap(g)), .REPEAT_CYCLES(cfg_rpt(g))
        ) u_dut (
            .clk(clk), .reset(reset), .btn(btn[g]), .clr(clr[g]),
            .db(db[g]), .event_tick(tick[g]), .count(cnt[g]), .sat(sat[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference model: db follows a level once DB consecutive synchronised samples agree.
    int m_p0 [N_DUT][N_CH];
    int m_p1 [N_DUT][N_CH];
    int m_rv [N_DUT][N_CH];
    int m_rl [N_DUT][N_CH];
    int m_db [N_DUT][N_CH];
    int m_dbp[N_DUT][N_CH];
    int m_hi [N_DUT][N_CH];
    int m_tk [N_DUT][N_CH];
    int m_cn [N_DUT][N_CH];
    int m_st [N_DUT][N_CH];
    int hold_left [N_DUT][N_CH];

    typedef struct {
        int n;
        int b;
        int exp_db;
        int exp_tick;
        int exp_cnt;
    } vec_t;
    vec_t t1 [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int g, input int c);
        return int'(cnt[g][c*CNT_W +: CNT_W]);
    endfunction

    task automatic model_step();
        for (int g = 0; g < N_DUT; g++) begin
            for (int c = 0; c < N_CH; c++) begin
                int s;
                int ntk;
                int ncn;
                int nst;
                int nd;
                bit rising;
                bit falling;
                if (reset) begin
                    m_p0[g][c] = 0; m_p1[g][c] = 0; m_rv[g][c] = 0; m_rl[g][c] = 0;
                    m_db[g][c] = 0; m_dbp[g][c] = 0; m_hi[g][c] = 0;
                    m_tk[g][c] = 0; m_cn[g][c] = 0; m_st[g][c] = 0;
                end else begin
                    ncn = m_cn[g][c];
                    nst = m_st[g][c];
                    if (clr[g][c]) begin
                        ncn = 0;
                        nst = 0;
                    end else if (m_tk[g][c] != 0) begin
                        if (cfg_wrap(g) != 0)       ncn = (m_cn[g][c] + 1) % (MAXV + 1);
                        else if (m_cn[g][c] == MAXV) nst = 1;
                        else                         ncn = m_cn[g][c] + 1;
                    end
                    rising  = (m_db[g][c] == 1) && (m_dbp[g][c] == 0);
                    falling = (m_db[g][c] == 0) && (m_dbp[g][c] == 1);
                    ntk = 0;
                    if (cfg_mode(g) == 0 && rising)             ntk = 1;
                    if (cfg_mode(g) == 1 && falling)            ntk = 1;
                    if (cfg_mode(g) == 2 && (rising || falling)) ntk = 1;
                    if (cfg_rpt(g) > 0 && cfg_mode(g) != 1 && m_db[g][c] == 1 &&
                        m_hi[g][c] > 1 && ((m_hi[g][c] - 1) % cfg_rpt(g)) == 0)
                        ntk = 1;
                    s = m_p1[g][c];
                    m_p1[g][c] = m_p0[g][c];
                    m_p0[g][c] = int'(btn[g][c]);
                    if (s == m_rv[g][c]) begin
                        if (m_rl[g][c] < DB) m_rl[g][c]++;
                    end else begin
                        m_rv[g][c] = s;
                        m_rl[g][c] = 1;
                    end
                    nd = (m_rl[g][c] >= DB) ? m_rv[g][c] : m_db[g][c];
                    m_dbp[g][c] = m_db[g][c];
                    m_db[g][c]  = nd;
                    m_hi[g][c]  = (nd != 0) ? m_hi[g][c] + 1 : 0;
                    m_tk[g][c]  = ntk;
                    m_cn[g][c]  = ncn;
                    m_st[g][c]  = nst;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < N_DUT; g++) begin
            for (int c = 0; c < N_CH; c++) begin
                check($sformatf("d%0d.c%0d db", g, c),    int'(db[g][c]),   m_db[g][c]);
                check($sformatf("d%0d.c%0d tick", g, c),  int'(tick[g][c]), m_tk[g][c]);
                check($sformatf("d%0d.c%0d count", g, c), cnt_of(g, c),    m_cn[g][c]);
                check($sformatf("d%0d.c%0d sat", g, c),   int'(sat[g][c]),  m_st[g][c]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle_inputs();
        for (int g = 0; g < N_DUT; g++) begin
            btn[g] = '0;
            clr[g] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        int found;
        int n_c;
        int n_d;
        int n_e;

        t1 = '{'{5, 1, 0, 0, 0}, '{1, 1, 1, 0, 0}, '{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 1},
               '{12, 1, 1, 0, 1}, '{5, 0, 1, 0, 1}, '{1, 0, 0, 0, 1}, '{1, 0, 0, 0, 1},
               '{6, 0, 0, 0, 1}};

        reset = 1'b1;
        idle_inputs();
        run(3);
        for (int g = 0; g < N_DUT; g++) begin
            check($sformatf("reset d%0d db", g),   int'(db[g]),   0);
            check($sformatf("reset d%0d tick", g), int'(tick[g]), 0);
            check($sformatf("reset d%0d count", g), int'(cnt[g]), 0);
            check($sformatf("reset d%0d sat", g),  int'(sat[g]),  0);
        end
        reset = 1'b0;

        // Single clean press: db at edge 6, one tick, count 1, release 6 edges later.
        foreach (t1[k]) begin
            btn[0][0] = t1[k].b[0];
            run(t1[k].n);
            check($sformatf("t1[%0d] db", k),    int'(db[0][0]),   t1[k].exp_db);
            check($sformatf("t1[%0d] tick", k),  int'(tick[0][0]), t1[k].exp_tick);
            check($sformatf("t1[%0d] count", k), cnt_of(0, 0),     t1[k].exp_cnt);
        end

        // Bounce every 2 cycles never reaches DB stable samples.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            btn[0][0] = ((k / 2) % 2) == 0;
            cycle();
            check("t2 db", int'(db[0][0]), 0);
            check("t2 tick", int'(tick[0][0]), 0);
        end
        btn[0][0] = 1'b0;
        run(10);
        check("t2 count", cnt_of(0, 0), 0);

        // Wrap versus saturate over 9 presses, then clear.
        do_reset();
        for (int p = 1; p <= 9; p++) begin
            btn[0][0] = 1'b1;
            btn[1][0] = 1'b1;
            run(8);
            btn[0][0] = 1'b0;
            btn[1][0] = 1'b0;
            run(8);
            check($sformatf("t3 wrap p%0d", p), cnt_of(0, 0), p % 8);
            check($sformatf("t3 sat-cnt p%0d", p), cnt_of(1, 0), (p < 7) ? p : 7);
            check($sformatf("t3 sat p%0d", p), int'(sat[1][0]), (p >= 8) ? 1 : 0);
            check($sformatf("t3 wrap sat p%0d", p), int'(sat[0][0]), 0);
        end
        clr[0][0] = 1'b1;
        clr[1][0] = 1'b1;
        cycle();
        clr[0][0] = 1'b0;
        clr[1][0] = 1'b0;
        check("t3 clr wrap count", cnt_of(0, 0), 0);
        check("t3 clr sat count", cnt_of(1, 0), 0);
        check("t3 clr sat", int'(sat[1][0]), 0);

        // clr coinciding with an event tick wins; the other channel still counts.
        do_reset();
        btn[0] = 2'b11;
        run(8);
        btn[0] = 2'b00;
        run(8);
        check("t4 pre count0", cnt_of(0, 0), 1);
        check("t4 pre count1", cnt_of(0, 1), 1);
        btn[0] = 2'b11;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (tick[0][1]) found = 1;
        end
        check("t4 tick seen", found, 1);
        check("t4 ch0 tick simultaneous", int'(tick[0][0]), 1);
        clr[0][1] = 1'b1;
        cycle();
        clr[0][1] = 1'b0;
        btn[0] = 2'b00;
        run(10);
        check("t4 count0", cnt_of(0, 0), 2);
        check("t4 count1", cnt_of(0, 1), 0);

        // Both-edge mode, press repeat, release mode without repeat.
        do_reset();
        n_c = 0;
        n_d = 0;
        n_e = 0;
        for (int k = 0; k < 50; k++) begin
            btn[2][0] = (k < 10);
            btn[3][0] = (k < 30);
            btn[4][0] = (k < 30);
            cycle();
            n_c += int'(tick[2][0]);
            n_d += int'(tick[3][0]);
            n_e += int'(tick[4][0]);
        end
        check("t5 both ticks", n_c, 2);
        check("t5 both count", cnt_of(2, 0), 2);
        check("t5 repeat ticks", n_d, 4);
        check("t5 repeat count", cnt_of(3, 0), 4);
        check("t5 release ticks", n_e, 1);
        check("t5 release count", cnt_of(4, 0), 1);

        // Reset mid-hold clears everything; a held button is re-debounced.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn[0][0] = 1'b1;
            run(8);
            btn[0][0] = 1'b0;
            run(8);
        end
        check("t6 pre count", cnt_of(0, 0), 3);
        btn[0][0] = 1'b1;
        run(8);
        check("t6 pre db", int'(db[0][0]), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6 rst db", int'(db[0]), 0);
        check("t6 rst tick", int'(tick[0]), 0);
        check("t6 rst count", int'(cnt[0]), 0);
        check("t6 rst sat", int'(sat[1]), 0);
        run(5);
        check("t6 db edge5", int'(db[0][0]), 0);
        run(1);
        check("t6 db edge6", int'(db[0][0]), 1);
        run(2);
        check("t6 count", cnt_of(0, 0), 1);
        btn[0][0] = 1'b0;
        run(8);

        // Random levels with varied hold lengths, sparse clears and resets.
        do_reset();
        for (int g = 0; g < N_DUT; g++)
            for (int c = 0; c < N_CH; c++)
                hold_left[g][c] = 0;
        for (int k = 0; k < 2000; k++) begin
            for (int g = 0; g < N_DUT; g++) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (hold_left[g][c] == 0) begin
                        btn[g][c] = ~btn[g][c];
                        hold_left[g][c] = int'($urandom_range(1, 12));
                    end
                    hold_left[g][c]--;
                    clr[g][c] = ($urandom_range(0, 59) == 0);
                end
            end
            reset = ($urandom_range(0, 799) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        run(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
